pipe_alu_mem: RTL and testbench

Parametrised single-clock successor to the two-phase register/ALU/memory pipeline. It issues one instruction per cycle, in the form rd <= func(rs1, rs2) plus mem[addr] <= result. It flows through three stages: operand fetch, ALU, then register writeback and store. Unlike the previous generation, it tracks per-stage valid bits, bypasses RAW hazards between back-to-back instructions, and exposes a registered memory read port for checking.

---
 rtl/pipe_alu_mem.sv | 134 +++++++++++++
 tb/tb_pipe_alu_mem.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_alu_mem.sv
// pipe_alu_mem: operand fetch -> ALU -> writeback/store pipeline, one instruction per cycle, never stalls.
// z at +1, regbank at +2, memory at +3; `define PIPE_FWD_EN to add the RAW bypass from S1/S2.
module pipe_alu_mem #(
  parameter  int DW   = 16,
  parameter  int NREG = 16,
  parameter  int AW   = 8,
  localparam int RW   = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [RW-1:0] rs1,
  input  logic [RW-1:0] rs2,
  input  logic [RW-1:0] rd,
  input  logic [3:0]    func,
  input  logic [AW-1:0] addr,
  output logic [DW-1:0] z,
  output logic          z_valid,
  input  logic [AW-1:0] mem_raddr,
  output logic [DW-1:0] mem_rdata
);

  function automatic logic [DW-1:0] alu(input logic [3:0] f, input logic [DW-1:0] a, input logic [DW-1:0] b);
    case (f)
      4'd0:    alu = a + b;
      4'd1:    alu = a - b;
      4'd2:    alu = a * b;
      4'd3:    alu = a;
      4'd4:    alu = b;
      4'd5:    alu = a & b;
      4'd6:    alu = a | b;
      4'd7:    alu = a ^ b;
      4'd8:    alu = ~a;
      4'd9:    alu = ~b;
      4'd10:   alu = a >> 1;
      4'd11:   alu = a << 1;
      default: alu = '0;
    endcase
  endfunction

  // stage 1: fetched operands and instruction fields
  logic          v1_q;
  logic [DW-1:0] a1_q, b1_q;
  logic [RW-1:0] rd1_q;
  logic [3:0]    func1_q;
  logic [AW-1:0] addr1_q;
  // stage 2: ALU result
  logic          v2_q;
  logic [DW-1:0] z_q;
  logic [RW-1:0] rd2_q;
  logic [AW-1:0] addr2_q;
  // stage 3: pending store
  logic          v3_q;
  logic [DW-1:0] d3_q;
  logic [AW-1:0] addr3_q;

  logic [DW-1:0] regbank_q [NREG];
  logic [DW-1:0] mem_q [2**AW];
  logic [DW-1:0] rdata_q;

  logic [DW-1:0] z_d, opa_d, opb_d;

  assign z_d = alu(func1_q, a1_q, b1_q);

`ifdef PIPE_FWD_EN
  // S1 is younger than S2, so it is checked last and wins on a shared rd.
  always_comb begin
    opa_d = regbank_q[rs1];
    opb_d = regbank_q[rs2];
    if (v2_q && rd2_q == rs1) opa_d = z_q;
    if (v2_q && rd2_q == rs2) opb_d = z_q;
    if (v1_q && rd1_q == rs1) opa_d = z_d;
    if (v1_q && rd1_q == rs2) opb_d = z_d;
  end
`else
  assign opa_d = regbank_q[rs1];
  assign opb_d = regbank_q[rs2];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q    <= 1'b0;
      a1_q    <= '0;
      b1_q    <= '0;
      rd1_q   <= '0;
      func1_q <= '0;
      addr1_q <= '0;
      v2_q    <= 1'b0;
      z_q     <= '0;
      rd2_q   <= '0;
      addr2_q <= '0;
      v3_q    <= 1'b0;
      d3_q    <= '0;
      addr3_q <= '0;
    end else begin
      v1_q    <= in_valid;
      a1_q    <= opa_d;
      b1_q    <= opb_d;
      rd1_q   <= rd;
      func1_q <= func;
      addr1_q <= addr;
      v2_q    <= v1_q;
      z_q     <= z_d;
      rd2_q   <= rd1_q;
      addr2_q <= addr1_q;
      v3_q    <= v2_q;
      d3_q    <= z_q;
      addr3_q <= addr2_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NREG; k++) regbank_q[k] <= DW'(k);
    end else if (v2_q) begin
      regbank_q[rd2_q] <= z_q;
    end
  end

  // memory contents survive reset; only the pipeline valids gate stores
  always_ff @(posedge clk) begin
    if (v3_q) mem_q[addr3_q] <= d3_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdata_q <= '0;
    else        rdata_q <= mem_q[mem_raddr];
  end

  assign z         = z_q;
  assign z_valid   = v2_q;
  assign mem_rdata = rdata_q;

endmodule

// File: tb/tb_pipe_alu_mem.sv
// Directed bench for pipe_alu_mem; expected values follow PIPE_FWD_EN when defined.
module tb_pipe_alu_mem;
  localparam int DW = 16;
  localparam int RW = 4;
  localparam int AW = 8;

`ifdef PIPE_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  localparam logic [3:0] ADD = 4'd0, SUB = 4'd1, MUL = 4'd2, SELA = 4'd3, SELB = 4'd4;
  localparam logic [3:0] AND_ = 4'd5, OR_ = 4'd6, XOR_ = 4'd7, NEGA = 4'd8, NEGB = 4'd9;
  localparam logic [3:0] SRA = 4'd10, SLA = 4'd11;

  // Results that depend on the bypass: SUB r14=r10-r5 at RAW distance 2, and
  // ADD r0=r12+r13 where r12 (distance 4) is already written but r13 (distance 2) is not.
  localparam logic [DW-1:0] SUB14_EXP = FWD ? 16'd3  : 16'd5;
  localparam logic [DW-1:0] ADD0_EXP  = FWD ? 16'd38 : 16'd37;
  localparam logic [DW-1:0] R4_EXP    = FWD ? 16'd2  : 16'd9;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic [RW-1:0] rs1, rs2, rd;
  logic [3:0]    func;
  logic [AW-1:0] addr, mem_raddr;
  logic [DW-1:0] z, mem_rdata;
  logic          z_valid;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  pipe_alu_mem #(.DW(DW), .NREG(16), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .rs1(rs1), .rs2(rs2), .rd(rd), .func(func), .addr(addr),
    .z(z), .z_valid(z_valid), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] f, input logic [RW-1:0] d, input logic [RW-1:0] s1,
                       input logic [RW-1:0] s2, input logic [AW-1:0] a);
    in_valid = 1'b1;
    func = f;
    rd = d;
    rs1 = s1;
    rs2 = s2;
    addr = a;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    tick();
  endtask

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reads a register back through the ALU without changing it.
  task automatic peek(input string tag, input logic [RW-1:0] r, input logic [DW-1:0] exp);
    issue(SELA, r, r, 4'd0, 8'hFF);
    idle();
    chk(tag, z, exp);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  logic [DW-1:0] exp_mem [6];

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    rs1 = '0; rs2 = '0; rd = '0; func = '0; addr = '0; mem_raddr = '0;
    exp_mem = '{16'd8, 16'd24, 16'd14, SUB14_EXP, 16'd3, ADD0_EXP};

    tick();
    tick();
    chk("rst_z", z, 16'd0);
    chk("rst_zv", DW'(z_valid), 16'd0);
    chk("rst_rdata", mem_rdata, 16'd0);
    rst_n = 1'b1;

    // known value at mem[200] for the mid-flight reset check
    issue(SELA, 4'd7, 4'd7, 4'd0, 8'd200);
    idle(); idle(); idle();

    // back-to-back sequence
    issue(ADD, 4'd10, 4'd3, 4'd5, 8'd125);
    chk("add_zv_early", DW'(z_valid), 16'd0);
    issue(MUL, 4'd12, 4'd3, 4'd8, 8'd126);
    chk("add_z", z, 16'd8);
    chk("add_zv", DW'(z_valid), 16'd1);
    issue(SUB, 4'd14, 4'd10, 4'd5, 8'd128);
    chk("mul_z", z, 16'd24);
    issue(SLA, 4'd13, 4'd7, 4'd0, 8'd127);
    chk("sub14_z", z, SUB14_EXP);
    issue(SUB, 4'd15, 4'd10, 4'd5, 8'd129);
    chk("sla_z", z, 16'd14);
    issue(ADD, 4'd0, 4'd12, 4'd13, 8'd130);
    chk("sub15_z", z, 16'd3);
    idle();
    chk("add0_z", z, ADD0_EXP);
    chk("add0_zv", DW'(z_valid), 16'd1);
    idle();
    chk("bubble_zv", DW'(z_valid), 16'd0);

    for (int i = 0; i < 6; i++) begin
      mem_raddr = AW'(125 + i);
      idle();
      chk($sformatf("mem%0d", 125 + i), mem_rdata, exp_mem[i]);
    end
    peek("r10", 4'd10, 16'd8);
    peek("r14", 4'd14, SUB14_EXP);
    peek("r0", 4'd0, ADD0_EXP);

    // read and store to the same address on one edge
    mem_raddr = 8'd126;
    issue(SELA, 4'd11, 4'd1, 4'd0, 8'd126);
    idle(); idle(); idle();
    chk("rdw_old", mem_rdata, 16'd24);
    idle();
    chk("rdw_new", mem_rdata, 16'd1);

    // bubbles: RAW distance 3 reads the written register in both builds
    do_reset();
    issue(ADD, 4'd10, 4'd3, 4'd5, 8'd250);
    idle(); idle();
    issue(SUB, 4'd14, 4'd10, 4'd5, 8'd251);
    idle();
    chk("bubble_sub", z, 16'd3);

    // two writers to r9, then a reader
    issue(SELA, 4'd9, 4'd1, 4'd0, 8'd252);
    issue(SELA, 4'd9, 4'd2, 4'd0, 8'd253);
    chk("r9a_z", z, 16'd1);
    issue(ADD, 4'd4, 4'd9, 4'd0, 8'd254);
    chk("r9b_z", z, 16'd2);
    idle();
    chk("r4_z", z, R4_EXP);
    idle(); idle();
    peek("r9_final", 4'd9, 16'd2);

    // remaining ALU opcodes
    issue(AND_, 4'd11, 4'd5, 4'd6, 8'd240);
    issue(OR_, 4'd11, 4'd5, 4'd6, 8'd240);
    chk("and_z", z, 16'h0004);
    issue(XOR_, 4'd11, 4'd5, 4'd6, 8'd240);
    chk("or_z", z, 16'h0007);
    issue(NEGA, 4'd11, 4'd5, 4'd6, 8'd240);
    chk("xor_z", z, 16'h0003);
    issue(SRA, 4'd11, 4'd7, 4'd6, 8'd240);
    chk("nega_z", z, 16'hFFFA);
    issue(4'd13, 4'd11, 4'd5, 4'd6, 8'd240);
    chk("sra_z", z, 16'h0003);
    issue(SELB, 4'd11, 4'd5, 4'd6, 8'd240);
    chk("op13_z", z, 16'h0000);
    idle();
    chk("selb_z", z, 16'h0006);

    // overflow wraps modulo 2**DW
    issue(NEGB, 4'd1, 4'd0, 4'd0, 8'd241);
    idle();
    chk("negb_z", z, 16'hFFFF);
    idle();
    issue(ADD, 4'd2, 4'd1, 4'd1, 8'd242);
    idle();
    chk("ovf_z", z, 16'hFFFE);

    // reset while MUL r12 is in flight
    mem_raddr = 8'd200;
    issue(MUL, 4'd12, 4'd3, 4'd8, 8'd200);
    idle();
    chk("mf_z_pre", z, 16'd24);
    rst_n = 1'b0;
    #1;
    chk("mf_z", z, 16'd0);
    chk("mf_zv", DW'(z_valid), 16'd0);
    chk("mf_rdata", mem_rdata, 16'd0);
    tick(); tick(); tick();
    rst_n = 1'b1;
    peek("mf_r12", 4'd12, 16'd12);
    mem_raddr = 8'd200;
    idle();
    chk("mf_mem200", mem_rdata, 16'd7);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
